// File: rtl/apb_controller.sv
// ---------------------------------------------------------------------------
// apb_controller
//   AHB-to-APB bridge control FSM. It accepts an AHB address phase and runs
//   one APB transfer: a single setup cycle followed by a single enable cycle.
//   Reads take READ -> RENABLE. Writes take WWAIT -> WRITE -> WENABLE, where
//   WWAIT gives the AHB write data time to arrive. A new request seen in
//   RENABLE or WENABLE starts the next transfer with no IDLE cycle between.
//
// Ports
//   Hclk       in   1   system clock, rising edge
//   Hresetn    in   1   asynchronous active-low reset
//   valid      in   1   AHB transfer request (address phase)
//   Hwrite     in   1   1 = write, 0 = read, sampled with valid
//   Haddr      in  32   AHB address, sampled with valid
//   tempselx   in   3   one-hot peripheral select, sampled with valid
//   Hwdata     in  32   AHB write data, one cycle after the address phase
//   Prdata     in  32   read data returned by the APB side
//   Pwrite     out  1   APB direction (registered)
//   Penable    out  1   APB enable strobe (registered)
//   Pselx      out  3   APB one-hot select (registered)
//   Paddr      out 32   APB address (registered, holds between transfers)
//   Pwdata     out 32   APB write data (registered, holds between transfers)
//   Hreadyout  out  1   AHB ready back to master (registered)
//   Hrdata     out 32   AHB read data, Prdata while in RENABLE, else 0
// ---------------------------------------------------------------------------
module apb_controller (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        valid,
  input  logic        Hwrite,
  input  logic [31:0] Haddr,
  input  logic [2:0]  tempselx,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic        Pwrite,
  output logic        Penable,
  output logic [2:0]  Pselx,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Hreadyout,
  output logic [31:0] Hrdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    RENABLE = 3'd2,
    WWAIT   = 3'd3,
    WRITE   = 3'd4,
    WENABLE = 3'd5
  } state_t;

  state_t     state;
  logic [2:0] sel_q;   // select latched at the address phase
  logic       start;

  // A request with no peripheral selected is not a transfer at all.
  assign start = valid && (tempselx != 3'b000);

  // Read data passes straight through only during the enable cycle of a read.
  always_comb begin
    Hrdata = (state == RENABLE) ? Prdata : 32'h0;
  end

  // Outputs are assigned alongside the state they belong to, so every output
  // reflects the state being entered and comes straight from a flop.
  // NOTE: sequential state uses non-blocking assignments only; a blocking
  // assignment here would let later statements in the same block see the
  // new value and break the flop-to-flop behaviour.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= IDLE;
      sel_q     <= 3'b000;
      Pselx     <= 3'b000;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= 32'h0;
      Pwdata    <= 32'h0;
      Hreadyout <= 1'b1;
    end else begin
      case (state)
        // Decision points: idle, or the last cycle of a transfer.
        IDLE, RENABLE, WENABLE: begin
          Penable <= 1'b0;
          if (start) begin
            Paddr     <= Haddr;
            sel_q     <= tempselx;
            Hreadyout <= 1'b0;
            if (Hwrite) begin
              // Wait for the data phase before selecting the peripheral.
              state  <= WWAIT;
              Pselx  <= 3'b000;
              Pwrite <= 1'b0;
            end else begin
              state  <= READ;
              Pselx  <= tempselx;
              Pwrite <= 1'b0;
            end
          end else begin
            state     <= IDLE;
            Pselx     <= 3'b000;
            Pwrite    <= 1'b0;
            Hreadyout <= 1'b1;
          end
        end

        READ: begin
          state     <= RENABLE;
          Pselx     <= sel_q;
          Pwrite    <= 1'b0;
          Penable   <= 1'b1;
          Hreadyout <= 1'b1;
        end

        // Hwdata is valid now, one cycle after the address phase.
        WWAIT: begin
          state     <= WRITE;
          Pwdata    <= Hwdata;
          Pselx     <= sel_q;
          Pwrite    <= 1'b1;
          Penable   <= 1'b0;
          Hreadyout <= 1'b0;
        end

        WRITE: begin
          state     <= WENABLE;
          Pselx     <= sel_q;
          Pwrite    <= 1'b1;
          Penable   <= 1'b1;
          Hreadyout <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          Pselx     <= 3'b000;
          Penable   <= 1'b0;
          Pwrite    <= 1'b0;
          Hreadyout <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_controller.sv
// ---------------------------------------------------------------------------
// tb_apb_controller
//   Self-checking bench for apb_controller: a directed vector table, a
//   reset-mid-write sequence and a randomized run against a transaction-level
//   reference model (transfer kind plus cycle age within the transfer).
// ---------------------------------------------------------------------------
module tb_apb_controller;

  logic        Hclk;
  logic        Hresetn;
  logic        valid;
  logic        Hwrite;
  logic [31:0] Haddr;
  logic [2:0]  tempselx;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        Pwrite;
  logic        Penable;
  logic [2:0]  Pselx;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Hreadyout;
  logic [31:0] Hrdata;

  int vectors     = 0;
  int miscompares = 0;

  apb_controller dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .valid     (valid),
    .Hwrite    (Hwrite),
    .Haddr     (Haddr),
    .tempselx  (tempselx),
    .Hwdata    (Hwdata),
    .Prdata    (Prdata),
    .Pwrite    (Pwrite),
    .Penable   (Penable),
    .Pselx     (Pselx),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Hreadyout (Hreadyout),
    .Hrdata    (Hrdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  // -------------------------------------------------------------------------
  // Comparison helper
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: tracks the transfer in flight and how many cycles old
  // it is. A read spends age 1 in setup and age 2 in enable; a write spends
  // age 1 waiting for data, age 2 in setup and age 3 in enable.
  // -------------------------------------------------------------------------
  typedef enum {M_NONE, M_READ, M_WRITE} kind_t;

  kind_t       m_kind;
  int          m_age;
  logic [2:0]  m_sel;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;

  function automatic bit m_ready();
    return (m_kind == M_NONE) || (m_kind == M_READ && m_age == 2) ||
           (m_kind == M_WRITE && m_age == 3);
  endfunction

  function automatic bit m_setup();
    return (m_kind == M_READ && m_age == 1) || (m_kind == M_WRITE && m_age == 2);
  endfunction

  function automatic bit m_enable();
    return (m_kind == M_READ && m_age == 2) || (m_kind == M_WRITE && m_age == 3);
  endfunction

  task automatic model_reset();
    m_kind   = M_NONE;
    m_age    = 0;
    m_sel    = 3'b000;
    m_paddr  = 32'h0;
    m_pwdata = 32'h0;
  endtask

  // Called right after a rising edge with the inputs that were sampled there.
  task automatic model_step();
    if (m_ready()) begin
      if (valid && tempselx != 3'b000) begin
        m_kind  = Hwrite ? M_WRITE : M_READ;
        m_age   = 1;
        m_sel   = tempselx;
        m_paddr = Haddr;
      end else begin
        m_kind = M_NONE;
        m_age  = 0;
      end
    end else begin
      if (m_kind == M_WRITE && m_age == 1) m_pwdata = Hwdata;
      m_age++;
    end
  endtask

  task automatic check_model(input string tag);
    bit active;
    active = m_setup() || m_enable();
    check({tag, ".Pselx"},     {29'h0, Pselx},    {29'h0, active ? m_sel : 3'b000});
    check({tag, ".Penable"},   {31'h0, Penable},  {31'h0, m_enable()});
    if (active)
      check({tag, ".Pwrite"},  {31'h0, Pwrite},   {31'h0, m_kind == M_WRITE});
    check({tag, ".Paddr"},     Paddr,             m_paddr);
    check({tag, ".Pwdata"},    Pwdata,            m_pwdata);
    check({tag, ".Hreadyout"}, {31'h0, Hreadyout}, {31'h0, m_ready()});
    check({tag, ".Hrdata"},    Hrdata,
          (m_kind == M_READ && m_age == 2) ? Prdata : 32'h0);
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [2:0] s, input logic [31:0] wd,
                       input logic [31:0] pd);
    valid    = v;
    Hwrite   = w;
    Haddr    = a;
    tempselx = s;
    Hwdata   = wd;
    Prdata   = pd;
  endtask

  // One clock: drive at the falling edge, compare against the model, then
  // let the rising edge advance both DUT and model.
  task automatic model_cycle(input string tag, input logic v, input logic w,
                             input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] wd, input logic [31:0] pd);
    @(negedge Hclk);
    drive(v, w, a, s, wd, pd);
    #1;
    check_model(tag);
    @(posedge Hclk);
    model_step();
  endtask

  // -------------------------------------------------------------------------
  // Directed vector table. Each row's inputs are driven at a falling edge and
  // the expected outputs are those visible at that same moment (i.e. the
  // result of all earlier rows).
  // -------------------------------------------------------------------------
  typedef struct {
    logic        v;
    logic        w;
    logic [31:0] a;
    logic [2:0]  s;
    logic [31:0] wd;
    logic [31:0] pd;
    logic [2:0]  e_sel;
    logic        e_en;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_rdy;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];

  initial begin
    logic [2:0]  rs;
    int          idx;

    // Single read, single write, back-to-back read->write, null select.
    //            v     w     addr          sel     hwdata        prdata        e_sel   en    wr    e_addr        e_wdata       rdy   e_rdata
    tbl[0]  = '{1'b1, 1'b0, 32'h8000_0010, 3'b001, 32'h0,        32'h0000_1111, 3'b000, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         3'b000, 32'h0,        32'h0000_2222, 3'b001, 1'b0, 1'b0, 32'h8000_0010, 32'h0,       1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         3'b000, 32'h0,        32'hCAFE_F00D, 3'b001, 1'b1, 1'b0, 32'h8000_0010, 32'h0,       1'b1, 32'hCAFE_F00D};
    tbl[3]  = '{1'b1, 1'b1, 32'h8400_0004, 3'b010, 32'h0,        32'h0000_3333, 3'b000, 1'b0, 1'b0, 32'h8000_0010, 32'h0,       1'b1, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0000_1234, 3'b100, 32'hDEAD_BEEF, 32'h0000_4444, 3'b000, 1'b0, 1'b0, 32'h8400_0004, 32'h0,       1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'hFFFF_0000, 3'b100, 32'h0,        32'h0,        3'b010, 1'b0, 1'b1, 32'h8400_0004, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h8000_0000, 3'b001, 32'h0,        32'h0,        3'b010, 1'b1, 1'b1, 32'h8400_0004, 32'hDEAD_BEEF, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 32'h8000_0004, 3'b100, 32'h0,        32'h0000_5555, 3'b001, 1'b0, 1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 32'h8000_0004, 3'b100, 32'h0,        32'hABCD_0123, 3'b001, 1'b1, 1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1, 32'hABCD_0123};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,         3'b000, 32'h0BAD_F00D, 32'h0,       3'b000, 1'b0, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         3'b000, 32'h0,        32'h0,        3'b100, 1'b0, 1'b1, 32'h8000_0004, 32'h0BAD_F00D, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 32'h9999_0000, 3'b000, 32'h0,        32'h0,        3'b100, 1'b1, 1'b1, 32'h8000_0004, 32'h0BAD_F00D, 1'b1, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 32'h9999_0000, 3'b000, 32'h0,        32'h0,        3'b000, 1'b0, 1'b0, 32'h8000_0004, 32'h0BAD_F00D, 1'b1, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         3'b000, 32'h0,        32'h0,        3'b000, 1'b0, 1'b0, 32'h8000_0004, 32'h0BAD_F00D, 1'b1, 32'h0};

    // ---------------- reset state ----------------
    Hresetn = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0);
    model_reset();
    #1 Hresetn = 1'b0;
    #2;
    check("rst.Pselx",     {29'h0, Pselx},    32'h0);
    check("rst.Penable",   {31'h0, Penable},  32'h0);
    check("rst.Pwrite",    {31'h0, Pwrite},   32'h0);
    check("rst.Paddr",     Paddr,             32'h0);
    check("rst.Pwdata",    Pwdata,            32'h0);
    check("rst.Hreadyout", {31'h0, Hreadyout}, 32'h1);
    check("rst.Hrdata",    Hrdata,            32'h0);
    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    Hresetn = 1'b1;

    // ---------------- directed table ----------------
    for (int i = 0; i < NVEC; i++) begin
      @(negedge Hclk);
      drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].wd, tbl[i].pd);
      #1;
      check($sformatf("vec%0d.Pselx", i),     {29'h0, Pselx},     {29'h0, tbl[i].e_sel});
      check($sformatf("vec%0d.Penable", i),   {31'h0, Penable},   {31'h0, tbl[i].e_en});
      if (tbl[i].e_sel != 3'b000)
        check($sformatf("vec%0d.Pwrite", i),  {31'h0, Pwrite},    {31'h0, tbl[i].e_wr});
      check($sformatf("vec%0d.Paddr", i),     Paddr,              tbl[i].e_addr);
      check($sformatf("vec%0d.Pwdata", i),    Pwdata,             tbl[i].e_wdata);
      check($sformatf("vec%0d.Hreadyout", i), {31'h0, Hreadyout}, {31'h0, tbl[i].e_rdy});
      check($sformatf("vec%0d.Hrdata", i),    Hrdata,             tbl[i].e_rdata);
      @(posedge Hclk);
      model_step();
    end

    // ---------------- reset in the middle of a write ----------------
    model_cycle("rw.start", 1'b1, 1'b1, 32'h8800_0020, 3'b100, 32'h0, 32'h0);
    model_cycle("rw.wwait", 1'b0, 1'b0, 32'h0, 3'b000, 32'h1357_9BDF, 32'h0);
    @(negedge Hclk);
    drive(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h7777_7777);
    #1;
    check_model("rw.write");
    #2 Hresetn = 1'b0;
    #1;
    check("rw.rst.Pselx",     {29'h0, Pselx},     32'h0);
    check("rw.rst.Penable",   {31'h0, Penable},   32'h0);
    check("rw.rst.Paddr",     Paddr,              32'h0);
    check("rw.rst.Pwdata",    Pwdata,             32'h0);
    check("rw.rst.Hreadyout", {31'h0, Hreadyout}, 32'h1);
    check("rw.rst.Hrdata",    Hrdata,             32'h0);
    model_reset();
    @(posedge Hclk);
    #1;
    check("rw.noenable", {31'h0, Penable}, 32'h0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    model_cycle("rw.rd0", 1'b1, 1'b0, 32'h8000_0040, 3'b010, 32'h0, 32'h0);
    model_cycle("rw.rd1", 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0);
    model_cycle("rw.rd2", 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h2468_ACE0);
    model_cycle("rw.rd3", 1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0);

    // ---------------- randomized run against the model ----------------
    for (int n = 0; n < 400; n++) begin
      idx = $urandom_range(0, 3);
      rs  = (idx == 0) ? 3'b000 : 3'(3'b001 << (idx - 1));
      model_cycle("rand", ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                  $urandom, rs, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_controller.md
APB_CONTROLLER -- requirements
Module: apb_controller

Interface
REQ-001 Hclk  in  1  single system clock; all state updates on rising edge.
REQ-002 Hresetn  in  1  asynchronous active-low reset.
REQ-003 valid  in  1  AHB-side transfer request, qualified in the address phase.
REQ-004 Hwrite  in  1  1=write, 0=read, sampled with valid.
REQ-005 Haddr  in  32  AHB address, sampled with valid.
REQ-006 tempselx  in  3  one-hot peripheral select, sampled with valid.
REQ-007 Hwdata  in  32  AHB write data, presented one cycle after the address phase.
REQ-008 Prdata  in  32  read data from the APB interface stage.
REQ-009 Pwrite, Penable  out  1 each  APB direction and enable strobe, registered.
REQ-010 Pselx  out  3  APB one-hot select, registered.
REQ-011 Paddr, Pwdata  out  32 each  APB address and write data, registered.
REQ-012 Hreadyout  out  1  AHB ready back to master.
REQ-013 Hrdata  out  32  AHB read data.

Function
REQ-014 The FSM SHALL have six states: IDLE, READ, RENABLE, WWAIT, WRITE, WENABLE.
REQ-015 Start condition: valid=1 and tempselx!=000.
- valid=1 with tempselx=000 SHALL be ignored, with no APB activity.
REQ-016 Decision in IDLE, RENABLE or WENABLE:
- start and Hwrite=0 -> READ
- start and Hwrite=1 -> WWAIT
- otherwise -> IDLE
REQ-017 Fixed transitions: READ->RENABLE, WWAIT->WRITE, WRITE->WENABLE.
REQ-018 On any start transition, the block SHALL latch Haddr into Paddr and tempselx into an internal select register.
REQ-019 In WWAIT, the block SHALL latch Hwdata into Pwdata.
REQ-020 Per-state outputs SHALL be as follows:
- IDLE and WWAIT: Pselx=000, Penable=0.
- READ: Pselx=latched select, Pwrite=0, Penable=0.
- RENABLE: Pselx=latched select, Pwrite=0, Penable=1.
- WRITE: Pselx=latched select, Pwrite=1, Penable=0.
- WENABLE: Pselx=latched select, Pwrite=1, Penable=1.
REQ-021 Hreadyout SHALL be 1 in IDLE, RENABLE and WENABLE, and 0 in READ, WWAIT and WRITE.
REQ-022 Hrdata SHALL equal Prdata combinationally while in RENABLE, and 0 otherwise.
REQ-023 Paddr and Pwdata SHALL hold their last latched values between transfers.
REQ-024 Latency:
- Read: 2 cycles from address phase to completion (READ, RENABLE).
- Write: 3 cycles (WWAIT, WRITE, WENABLE).
REQ-025 Back-to-back: a start seen in RENABLE or WENABLE SHALL enter the next setup state with no IDLE cycle in between.
- Any read/write mix SHALL be supported.
REQ-026 Every APB transfer SHALL be exactly one setup cycle (Penable=0) followed by one enable cycle (Penable=1), with Pselx, Paddr and Pwrite stable across both.
REQ-027 Input changes during READ, WWAIT or WRITE SHALL NOT alter the transfer in flight, except Hwdata, which is sampled in WWAIT.

Reset
REQ-028 Hresetn=0 SHALL immediately force, without waiting for a clock edge:
- state=IDLE
- Pselx=000, Penable=0, Pwrite=0, Paddr=0, Pwdata=0
- internal select register=000
- Hreadyout=1, Hrdata=0
REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no enable cycle issued.
- The first start after release SHALL behave as from IDLE.

Verification
REQ-030 Single read:
- Stimulus: valid=1, Hwrite=0, Haddr=0x8000_0010, tempselx=001.
- Response: next cycle Pselx=001, Paddr=0x8000_0010, Penable=0, Hreadyout=0.
- Then Penable=1 and Hreadyout=1, with Hrdata=Prdata.
REQ-031 Single write:
- Stimulus: valid=1, Hwrite=1, Haddr=0x8400_0004, tempselx=010, then Hwdata=0xDEAD_BEEF.
- Response: a WWAIT cycle, then WRITE with Pwdata=0xDEAD_BEEF and Pwrite=1, then WENABLE with Penable=1 and Hreadyout=1.
REQ-032 Back-to-back:
- Stimulus: read 0x8000_0000, then write 0x8000_0004 issued in the RENABLE cycle.
- Response: WWAIT follows RENABLE directly, with no IDLE cycle.
REQ-033 Null select:
- Stimulus: valid=1, tempselx=000.
- Response: state stays IDLE, Pselx=000, Hreadyout=1.
REQ-034 Reset mid-write:
- Stimulus: Hresetn=0 asserted in WRITE.
- Response: Pselx=000, Penable=0, Paddr=0 and Hreadyout=1 immediately.
- A subsequent read completes normally.
